// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings and default vectors for the datapath.
// Contents: PC-source select typedef, reset/trap vector defaults.
package cpu_pkg;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUREG = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_RET    = 2'b11
    } pcsrc_e;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0080;

endpackage

// File: rtl/return_addr_stack.sv
// return_addr_stack: circular return-address buffer, pointer + count.
// Ports: clk, rst (async high), push, pop, push_data -> top, empty, full.
// A push when full overwrites the oldest entry; push+pop replaces top.
module return_addr_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    top_idx;
    logic [PW-1:0]    wr_idx;
    logic             wr_en;
    logic             do_pop;

    // ptr_q is the next free slot; the top lives one below it.
    assign top_idx = ptr_q - PW'(1);
    assign top     = mem_q[top_idx];
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (PW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;

    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        if (push && do_pop) begin
            // Return and call together: swap the top in place.
            wr_en  = 1'b1;
            wr_idx = top_idx;
        end else if (push) begin
            wr_en = 1'b1;
            ptr_d = ptr_q + PW'(1);
            if (!full) begin
                cnt_d = cnt_q + (PW+1)'(1);
            end
        end else if (do_pop) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - (PW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Contents are don't-care after reset, so no reset on the array.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register, next-PC select, trap on bad targets, RAS.
// Ports: clk, rst, PCSource/PCWrite/PCWriteCond/Zero/RasPush, ALUOut,
//   ALURegisterOut, Immediate -> PC, NextPC, Trap, RasEmpty, RasFull.
// Macro PC_SEQUENCER_RAS_EN builds the return-address stack.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IMM_WIDTH  = 26,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR =
        DATA_WIDTH'(RESET_VECTOR_DEF),
    parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR =
        DATA_WIDTH'(TRAP_VECTOR_DEF),
    parameter int RAS_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            PCSource,
    input  logic                  PCWrite,
    input  logic                  PCWriteCond,
    input  logic                  Zero,
    input  logic                  RasPush,
    input  logic [DATA_WIDTH-1:0] ALUOut,
    input  logic [DATA_WIDTH-1:0] ALURegisterOut,
    input  logic [IMM_WIDTH-1:0]  Immediate,
    output logic [DATA_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] NextPC,
    output logic                  Trap,
    output logic                  RasEmpty,
    output logic                  RasFull
);

    localparam int JW = IMM_WIDTH + 2;
    // Bits of the PC replaced by a jump; the rest come from the PC.
    localparam logic [DATA_WIDTH-1:0] JMASK = DATA_WIDTH'({JW{1'b1}});

    pcsrc_e                src;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic                  trap_q, trap_d;
    logic [DATA_WIDTH-1:0] target;
    logic [DATA_WIDTH-1:0] jump_tgt;
    logic [DATA_WIDTH-1:0] ras_top;
    logic                  ras_empty;
    logic                  ras_full;
    logic                  trap_cond;
    logic                  update;

    assign src      = pcsrc_e'(PCSource);
    assign update   = PCWrite | (PCWriteCond & Zero);
    assign jump_tgt = (pc_q & ~JMASK) | DATA_WIDTH'({Immediate, 2'b00});

`ifdef PC_SEQUENCER_RAS_EN
    logic ras_push;
    logic ras_pop;

    // A trapping update must leave the stack untouched.
    assign ras_push = update & ~trap_cond & RasPush;
    assign ras_pop  = update & ~trap_cond & (src == PCSRC_RET);

    return_addr_stack #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_q),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );
`else
    logic ras_push_unused;
    localparam int RAS_DEPTH_UNUSED = RAS_DEPTH;

    assign ras_push_unused = RasPush;
    assign ras_top         = '0;
    assign ras_empty       = 1'b1;
    assign ras_full        = 1'b0;
`endif

    always_comb begin
        target    = ALUOut;
        trap_cond = 1'b0;
        unique case (src)
            PCSRC_ALU: begin
                target    = ALUOut;
                trap_cond = |ALUOut[1:0];
            end
            PCSRC_ALUREG: begin
                target    = ALURegisterOut;
                trap_cond = |ALURegisterOut[1:0];
            end
            PCSRC_JUMP: begin
                target = jump_tgt;
            end
            PCSRC_RET: begin
                // Always empty without the stack, so returns trap.
                target    = ras_top;
                trap_cond = ras_empty;
            end
        endcase
    end

    assign NextPC = trap_cond ? TRAP_VECTOR : target;
    assign pc_d   = update ? NextPC : pc_q;
    assign trap_d = update & trap_cond;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= RESET_VECTOR;
            trap_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            trap_q <= trap_d;
        end
    end

    assign PC       = pc_q;
    assign Trap     = trap_q;
    assign RasEmpty = ras_empty;
    assign RasFull  = ras_full;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed + random checks against a queue-based model.
// Builds with or without PC_SEQUENCER_RAS_EN.
module tb_pc_sequencer;

`ifdef PC_SEQUENCER_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif
    localparam int DEPTH = 4;
    localparam logic [31:0] TRAPV = 32'h0000_0080;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  PCSource = 2'b00;
    logic        PCWrite = 1'b0;
    logic        PCWriteCond = 1'b0;
    logic        Zero = 1'b0;
    logic        RasPush = 1'b0;
    logic [31:0] ALUOut = '0;
    logic [31:0] ALURegisterOut = '0;
    logic [25:0] Immediate = '0;
    logic [31:0] PC;
    logic [31:0] NextPC;
    logic        Trap;
    logic        RasEmpty;
    logic        RasFull;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_pc;
    logic        m_trap;
    logic [31:0] m_ras[$];

    pc_sequencer #(
        .DATA_WIDTH (32),
        .IMM_WIDTH  (26),
        .RAS_DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .PCSource       (PCSource),
        .PCWrite        (PCWrite),
        .PCWriteCond    (PCWriteCond),
        .Zero           (Zero),
        .RasPush        (RasPush),
        .ALUOut         (ALUOut),
        .ALURegisterOut (ALURegisterOut),
        .Immediate      (Immediate),
        .PC             (PC),
        .NextPC         (NextPC),
        .Trap           (Trap),
        .RasEmpty       (RasEmpty),
        .RasFull        (RasFull)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc   = 32'h0;
        m_trap = 1'b0;
        m_ras.delete();
    endtask

    // Target and trap decision from the rules, using the model state.
    task automatic model_sel(output logic [31:0] tgt, output bit trp);
        trp = 1'b0;
        tgt = 32'h0;
        case (PCSource)
            2'd0: begin tgt = ALUOut; trp = (ALUOut % 4) != 0; end
            2'd1: begin
                tgt = ALURegisterOut;
                trp = (ALURegisterOut % 4) != 0;
            end
            2'd2: tgt = (m_pc / 32'h1000_0000) * 32'h1000_0000
                        + 32'(Immediate) * 4;
            default: begin
                if (RAS_EN && m_ras.size() > 0)
                    tgt = m_ras[m_ras.size()-1];
                else
                    trp = 1'b1;
            end
        endcase
        if (trp) tgt = TRAPV;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".pc"}, PC, m_pc);
        chk({tag, ".trap"}, 32'(Trap), 32'(m_trap));
        chk({tag, ".empty"}, 32'(RasEmpty), 32'(m_ras.size() == 0));
        chk({tag, ".full"}, 32'(RasFull), 32'(m_ras.size() == DEPTH));
    endtask

    // Drive one cycle of inputs, check NextPC, clock, check state.
    task automatic step(input string tag, input logic [1:0] s,
                        input logic w, input logic wc, input logic z,
                        input logic push, input logic [31:0] a,
                        input logic [31:0] ar, input logic [25:0] im);
        logic [31:0] tgt;
        bit          trp;
        bit          upd;
        logic [31:0] old_pc;
        PCSource       = s;
        PCWrite        = w;
        PCWriteCond    = wc;
        Zero           = z;
        RasPush        = push;
        ALUOut         = a;
        ALURegisterOut = ar;
        Immediate      = im;
        #2;
        model_sel(tgt, trp);
        chk({tag, ".next"}, NextPC, tgt);
        upd = w | (wc & z);
        @(posedge clk);
        #1;
        old_pc = m_pc;
        m_trap = upd & trp;
        if (upd) begin
            m_pc = tgt;
            if (!trp && RAS_EN) begin
                if (s == 2'd3) void'(m_ras.pop_back());
                if (push) begin
                    m_ras.push_back(old_pc);
                    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                end
            end
        end
        check_state(tag);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        model_reset();
        #3;
        check_state("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_state("reset_rel");

        step("alu4", 2'd0, 1, 0, 0, 0, 32'h4, 32'h0, 26'h0);
        step("set_hi", 2'd0, 1, 0, 0, 0, 32'h4000_0010, 32'h0, 26'h0);
        step("jump", 2'd2, 1, 0, 0, 0, 32'h0, 32'h0, 26'h000_0100);
        step("cond_z0", 2'd1, 0, 1, 0, 0, 32'h0, 32'h20, 26'h0);
        step("cond_z1", 2'd1, 0, 1, 1, 0, 32'h0, 32'h20, 26'h0);
        step("misalign", 2'd0, 1, 0, 0, 1, 32'h6, 32'h0, 26'h0);
        step("trap_end", 2'd0, 0, 0, 0, 0, 32'h6, 32'h0, 26'h0);
        step("mis_reg", 2'd1, 1, 0, 0, 0, 32'h0, 32'h21, 26'h0);

        // Five calls from PCs 0x10..0x50, then five returns.
        step("to10", 2'd0, 1, 0, 0, 0, 32'h10, 32'h0, 26'h0);
        for (int i = 2; i <= 6; i++)
            step("call", 2'd0, 1, 0, 0, 1, 32'(i * 16), 32'h0, 26'h0);
        for (int i = 0; i < 5; i++)
            step("ret", 2'd3, 1, 0, 0, 0, 32'h0, 32'h0, 26'h0);
        step("ret_hold", 2'd3, 0, 0, 0, 1, 32'h0, 32'h0, 26'h0);

        // Call and return on the same update.
        step("c1", 2'd0, 1, 0, 0, 1, 32'h200, 32'h0, 26'h0);
        step("c2", 2'd0, 1, 0, 0, 1, 32'h300, 32'h0, 26'h0);
        step("retcall", 2'd3, 1, 0, 0, 1, 32'h0, 32'h0, 26'h0);
        step("r2", 2'd3, 1, 0, 0, 0, 32'h0, 32'h0, 26'h0);
        step("r3", 2'd3, 1, 0, 0, 0, 32'h0, 32'h0, 26'h0);

        // Reset mid-cycle with an update pending.
        step("pre_rst", 2'd0, 1, 0, 0, 1, 32'h100, 32'h0, 26'h0);
        PCWrite = 1'b1;
        PCSource = 2'd0;
        ALUOut = 32'h44;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_state("async_rst");
        @(posedge clk);
        #1;
        check_state("rst_edge");
        rst = 1'b0;

        for (int i = 0; i < 400; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) rb[1:0] = 2'b00;
            step("rand", 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 2) != 0), 1'($urandom),
                 1'($urandom), 1'($urandom_range(0, 2) == 0),
                 ra, rb, 26'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter register and next-PC selector for the multicycle datapath. It replaces the purely combinational PC-source mux. It holds the PC and applies the multicycle update rule (`PCWrite`, or `PCWriteCond` with `Zero`). It forms true jump targets, traps on illegal or misaligned targets instead of driving all-ones, and optionally keeps a small return-address stack (RAS) for call and return. It sits between the control FSM, the ALU output register and the instruction-memory address port.

## Interface
Parameters:
- `DATA_WIDTH`, 32, PC/target width; must be ≥ `IMM_WIDTH`+2
- `IMM_WIDTH`, 26, jump immediate width
- `RESET_VECTOR`, 0, PC value after reset
- `TRAP_VECTOR`, 32'h0000_0080, PC loaded on any trap
- `RAS_DEPTH`, 4, RAS entries, a power of two ≥ 2 (used only with the macro)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `PCSource`  in  2  target select: 00 ALUOut, 01 ALURegisterOut, 10 jump, 11 RAS return
- `PCWrite`  in  1  unconditional update
- `PCWriteCond`  in  1  update if `Zero`
- `Zero`  in  1  ALU zero flag
- `RasPush`  in  1  push the current PC on this update (call)
- `ALUOut`  in  `DATA_WIDTH`  live ALU result
- `ALURegisterOut`  in  `DATA_WIDTH`  registered ALU result
- `Immediate`  in  `IMM_WIDTH`  jump field
- `PC`  out  `DATA_WIDTH`  current PC, registered
- `NextPC`  out  `DATA_WIDTH`  combinational target that the next update would load
- `Trap`  out  1  registered one-cycle pulse when a trap is taken
- `RasEmpty`, `RasFull`  out  1  stack status

## Operation
- update = `PCWrite` | (`PCWriteCond` & `Zero`). Without update, all state holds and `RasPush` is ignored.
- Target:
  - 00 → `ALUOut`
  - 01 → `ALURegisterOut`
  - 10 → {`PC`[DATA_WIDTH-1:IMM_WIDTH+2], `Immediate`, 2'b00}
  - 11 → RAS top
- Trap conditions, evaluated on update:
  - source 00 or 01 with target[1:0] ≠ 0 (misaligned)
  - source 11 with RAS empty, or source 11 with the macro absent
- On trap: `PC` ← `TRAP_VECTOR`, `Trap`=1 for exactly one cycle, and there is no RAS change (push suppressed).
- RAS is a circular buffer with pointer and count.
  - Push: write the current `PC` at top, pointer+1 mod `RAS_DEPTH`, count saturates at `RAS_DEPTH`. A push when full overwrites the oldest entry; `RasFull` stays 1.
  - Pop (source 11, non-empty): target = top, pointer−1, count−1.
  - Pop and push on the same update: the target is the old top. The top entry is replaced by the current `PC` and count is unchanged.
- `NextPC` shows the selected target, or `TRAP_VECTOR` if the trap condition holds, independent of update.

## Timing
- Reset, asynchronous: `PC`=`RESET_VECTOR`, `Trap`=0, RAS count=0, pointer=0, `RasEmpty`=1, `RasFull`=0. The RAS contents are don't-care.
- One-cycle latency: a target selected in cycle n appears on `PC` after edge n.
- `Trap` is asserted in the cycle following the trapping edge. It is low on the next edge unless another trap occurs.
- Reset asserted mid-operation overrides any pending update on the same edge.
- Back-to-back updates on every cycle are legal.

## Configuration
- `PC_SEQUENCER_RAS_EN` defined: the RAS is built with `RAS_DEPTH` entries, and `RasPush` and source 11 operate as above.
- Macro not defined: no RAS storage. `RasPush` is ignored. Source 11 always traps. `RasEmpty`=1 and `RasFull`=0 constantly.

## Structure
- Shared package `cpu_pkg`:
  - PC-source encodings `PCSRC_ALU`, `PCSRC_ALUREG`, `PCSRC_JUMP`, `PCSRC_RET` as a 2-bit typedef
  - default `RESET_VECTOR` and `TRAP_VECTOR` constants
- One sub-module, `return_addr_stack`: the circular buffer with push/pop and empty/full. It is instantiated only under the macro.

## Test plan
- Reset, then `PCWrite`=1, source 00, `ALUOut`=0x4 → `PC`=0x4 after one edge, `Trap`=0.
- `PC`=0x4000_0010, source 10, `Immediate`=0x000_0100 → `PC`=0x4000_0400.
- `PCWriteCond`=1 with `Zero`=0, then with `Zero`=1, `ALURegisterOut`=0x20 → `PC` first holds, then becomes 0x20.
- Source 00 with `ALUOut`=0x6 → `PC`=0x80, `Trap` high for exactly one cycle, RAS unchanged.
- With the macro, `RAS_DEPTH`=4: push at PC 0x10, 0x20, 0x30, 0x40, 0x50 → `RasFull`=1. Five returns → 0x50, 0x40, 0x30, 0x20, then `RasEmpty`=1 and the fifth return traps to 0x80.
- Without the macro, source 11 with `PCWrite`=1 → `PC`=0x80 and `Trap` pulses. Assert `rst` mid-stream → `PC`=0 immediately, without waiting for an edge.
